// File: rtl/fetch_bus_ctrl.sv
// Purpose: instruction-fetch bus master. It requests the bus, issues one strobed read per fetch and hands the word to IF/ID.
// Latency: bus_as comes 1 cycle after grant. insn/busy update 1 cycle after bus_rdy. A fetch is abandoned after TIMEOUT cycles in WAIT.
// Backpressure: REQ waits indefinitely for bus_grnt. HOLD keeps insn while stall=1. busy=1 tells the pipeline to stall.
//
// Ports: clk, reset (async active-low); pc, stall, flush from the pipeline;
//        bus_req/bus_grnt arbitration; bus_as/bus_addr/bus_rdy/bus_rd_data read channel;
//        insn to IF/ID, busy (combinational from state), err (one-cycle timeout pulse).

`ifndef ISA_NOP
`define ISA_NOP 32'h0000_0013
`endif

module fetch_bus_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] pc,
    input  logic        stall,
    input  logic        flush,
    output logic        bus_req,
    input  logic        bus_grnt,
    output logic        bus_as,
    output logic [29:0] bus_addr,
    input  logic        bus_rdy,
    input  logic [31:0] bus_rd_data,
    output logic [31:0] insn,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACCESS,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_as_q, bus_as_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic [31:0] insn_q, insn_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        flush_pend_q, flush_pend_d;
    logic        timed_out;

    // The last permitted WAIT cycle. The counter resolves here, so it never wraps.
    assign timed_out = (cnt_q == (TIMEOUT - 8'd1));

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_as_d     = 1'b0;
        bus_addr_d   = bus_addr_q;
        insn_d       = insn_q;
        err_d        = 1'b0;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (!stall) begin
                    state_d   = ST_REQ;
                    bus_req_d = 1'b1;
                end
            end

            // A flush here needs no action: the address is captured from pc only at grant.
            ST_REQ: begin
                bus_req_d = 1'b1;
                if (bus_grnt) begin
                    state_d    = ST_ACCESS;
                    bus_as_d   = 1'b1;
                    bus_addr_d = pc;
                end
            end

            ST_ACCESS: begin
                state_d = ST_WAIT;
                cnt_d   = 8'd0;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end

            ST_WAIT: begin
                if (bus_rdy || timed_out) begin
                    if (flush_pend_q || flush) begin
                        // The bus transfer finished, but its result is stale.
                        // Drop the result and refetch at once, without releasing the bus request.
                        insn_d       = `ISA_NOP;
                        flush_pend_d = 1'b0;
                        state_d      = ST_REQ;
                        bus_req_d    = 1'b1;
                    end else begin
                        state_d   = ST_HOLD;
                        bus_req_d = 1'b0;
                        // bus_rdy takes priority over a timeout in the same cycle.
                        if (bus_rdy) begin
                            insn_d = bus_rd_data;
                        end else begin
                            insn_d = `ISA_NOP;
                            err_d  = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (flush) begin
                        flush_pend_d = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (flush) begin
                    insn_d    = `ISA_NOP;
                    state_d   = ST_REQ;
                    bus_req_d = 1'b1;
                end else if (!stall) begin
                    state_d   = ST_REQ;
                    bus_req_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bus_req_q    <= 1'b0;
            bus_as_q     <= 1'b0;
            bus_addr_q   <= 30'd0;
            insn_q       <= `ISA_NOP;
            err_q        <= 1'b0;
            cnt_q        <= 8'd0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_as_q     <= bus_as_d;
            bus_addr_q   <= bus_addr_d;
            insn_q       <= insn_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus_req  = bus_req_q;
    assign bus_as   = bus_as_q;
    assign bus_addr = bus_addr_q;
    assign insn     = insn_q;
    assign err      = err_q;
    assign busy     = (state_q != ST_HOLD);

endmodule

// File: tb/tb_fetch_bus_ctrl.sv
// Purpose: self-checking bench for fetch_bus_ctrl, covering directed scenarios plus a randomized run against a transaction-level model.
// Latency: inputs are driven at negedge and sampled by the DUT at the following posedge. Outputs are compared at the next negedge.
// Backpressure: grant, ready and stall are randomized to exercise waiting in REQ, WAIT and HOLD.

`ifndef ISA_NOP
`define ISA_NOP 32'h0000_0013
`endif

module tb_fetch_bus_ctrl;

    localparam int          TMO = 4;
    localparam logic [31:0] NOP = `ISA_NOP;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] pc;
    logic        stall;
    logic        flush;
    logic        bus_req;
    logic        bus_grnt;
    logic        bus_as;
    logic [29:0] bus_addr;
    logic        bus_rdy;
    logic [31:0] bus_rd_data;
    logic [31:0] insn;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Expected outputs, maintained by the model process.
    logic        m_req, m_as, m_err, m_busy;
    logic [29:0] m_addr;
    logic [31:0] m_insn;
    bit          model_go = 1'b0;
    bit          model_on = 1'b0;

    fetch_bus_ctrl #(.TIMEOUT(8'(TMO))) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .stall       (stall),
        .flush       (flush),
        .bus_req     (bus_req),
        .bus_grnt    (bus_grnt),
        .bus_as      (bus_as),
        .bus_addr    (bus_addr),
        .bus_rdy     (bus_rdy),
        .bus_rd_data (bus_rd_data),
        .insn        (insn),
        .busy        (busy),
        .err         (err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge, seen from the model. The strobe and error pulses last one cycle only.
    task automatic tick();
        @(posedge clk);
        m_as  = 1'b0;
        m_err = 1'b0;
    endtask

    // Models a fetch as a sequence of phases:
    // request -> strobe -> wait up to TMO cycles -> deliver or discard -> hold.
    task automatic model_run();
        bit pend;
        bit done;
        int n;
        m_req  = 1'b0;
        m_as   = 1'b0;
        m_err  = 1'b0;
        m_busy = 1'b1;
        m_addr = '0;
        m_insn = NOP;
        tick();
        while (stall) tick();
        m_req = 1'b1;
        forever begin
            tick();
            while (!bus_grnt) tick();
            m_as   = 1'b1;
            m_addr = pc;
            tick();
            pend = flush;
            n    = 0;
            done = 1'b0;
            while (!done) begin
                tick();
                n++;
                done = bus_rdy || (n == TMO);
                if (!done) pend = pend | flush;
            end
            if (pend || flush) begin
                m_insn = NOP;
            end else begin
                m_insn = bus_rdy ? bus_rd_data : NOP;
                m_err  = !bus_rdy;
                m_req  = 1'b0;
                m_busy = 1'b0;
                done   = 1'b0;
                while (!done) begin
                    tick();
                    if (flush) m_insn = NOP;
                    done = flush || !stall;
                end
                m_req  = 1'b1;
                m_busy = 1'b1;
            end
        end
    endtask

    initial begin
        wait (model_go);
        model_run();
    end

    task automatic compare_all();
        if (model_on) begin
            chk("m_bus_req",  32'(bus_req),  32'(m_req));
            chk("m_bus_as",   32'(bus_as),   32'(m_as));
            chk("m_bus_addr", 32'(bus_addr), 32'(m_addr));
            chk("m_insn",     insn,          m_insn);
            chk("m_err",      32'(err),      32'(m_err));
            chk("m_busy",     32'(busy),     32'(m_busy));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bit found;
        reset       = 1'b0;
        stall       = 1'b1;
        flush       = 1'b0;
        pc          = '0;
        bus_grnt    = 1'b0;
        bus_rdy     = 1'b0;
        bus_rd_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_req",  32'(bus_req),  32'd0);
        chk("rst_as",   32'(bus_as),   32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_insn", insn,          NOP);
        chk("rst_err",  32'(err),      32'd0);
        chk("rst_busy", 32'(busy),     32'd1);

        // Basic fetch: address 0, data returned two cycles after the strobe.
        reset    = 1'b1;
        stall    = 1'b0;
        model_go = 1'b1;
        model_on = 1'b1;
        cyc();
        chk("first_req", 32'(bus_req), 32'd1);
        bus_grnt = 1'b1;
        cyc();
        chk("b2b_as", 32'(bus_as), 32'd1);
        chk("b2b_addr", 32'(bus_addr), 32'd0);
        bus_grnt    = 1'b0;
        cyc();
        chk("as_one_cycle", 32'(bus_as), 32'd0);
        bus_rdy     = 1'b1;
        bus_rd_data = 32'h1234_5678;
        cyc();
        chk("fetch_insn", insn, 32'h1234_5678);
        chk("fetch_busy", 32'(busy), 32'd0);
        bus_rdy = 1'b0;
        cyc();
        chk("rereq_busy", 32'(busy), 32'd1);
        chk("rereq_req", 32'(bus_req), 32'd1);

        // Hold the fetched instruction under stall for five cycles.
        bus_grnt = 1'b1;
        pc       = 30'h155;
        cyc();
        bus_grnt    = 1'b0;
        cyc();
        bus_rdy     = 1'b1;
        bus_rd_data = 32'hA5A5_0F0F;
        stall       = 1'b1;
        cyc();
        bus_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_insn", insn, 32'hA5A5_0F0F);
            chk("hold_req", 32'(bus_req), 32'd0);
            chk("hold_busy", 32'(busy), 32'd0);
        end
        stall = 1'b0;
        cyc();
        chk("unstall_req", 32'(bus_req), 32'd1);

        // Timeout: with no ready, err fires on the TMO-th WAIT cycle.
        bus_grnt = 1'b1;
        pc       = 30'h2AA;
        cyc();
        bus_grnt = 1'b0;
        cyc();
        for (int i = 0; i < TMO - 1; i++) begin
            cyc();
            chk("tmo_no_err_early", 32'(err), 32'd0);
        end
        cyc();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_insn", insn, NOP);
        chk("tmo_busy", 32'(busy), 32'd0);
        stall = 1'b1;
        cyc();
        chk("tmo_err_pulse", 32'(err), 32'd0);
        chk("tmo_hold", 32'(busy), 32'd0);
        stall = 1'b0;
        cyc();

        // Flush during WAIT: the bus data is discarded and the next fetch uses the new pc.
        bus_grnt = 1'b1;
        pc       = 30'h100;
        cyc();
        bus_grnt = 1'b0;
        cyc();
        flush    = 1'b1;
        cyc();
        flush    = 1'b0;
        cyc();
        cyc();
        bus_rdy     = 1'b1;
        bus_rd_data = 32'hDEAD_BEEF;
        cyc();
        chk("flush_insn", insn, NOP);
        chk("flush_err", 32'(err), 32'd0);
        chk("flush_req", 32'(bus_req), 32'd1);
        chk("flush_busy", 32'(busy), 32'd1);
        bus_rdy  = 1'b0;
        pc       = 30'h200;
        bus_grnt = 1'b1;
        cyc();
        chk("refetch_as", 32'(bus_as), 32'd1);
        chk("refetch_addr", 32'(bus_addr), 32'h200);
        bus_grnt    = 1'b0;
        cyc();
        bus_rdy     = 1'b1;
        bus_rd_data = 32'h0BAD_F00D;
        cyc();
        chk("refetch_insn", insn, 32'h0BAD_F00D);
        bus_rdy = 1'b0;
        cyc();

        // Ready arriving in the same cycle as the timeout: ready wins.
        bus_grnt = 1'b1;
        cyc();
        bus_grnt = 1'b0;
        cyc();
        for (int i = 0; i < TMO - 1; i++) cyc();
        bus_rdy     = 1'b1;
        bus_rd_data = 32'hC0DE_0039;
        cyc();
        chk("race_insn", insn, 32'hC0DE_0039);
        chk("race_err", 32'(err), 32'd0);
        bus_rdy = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(99) < 40);
            flush       = ($urandom_range(99) < 8);
            bus_grnt    = ($urandom_range(99) < 50);
            bus_rdy     = ($urandom_range(99) < 25);
            bus_rd_data = $urandom();
            pc          = 30'($urandom());
            cyc();
        end

        // Reset asserted mid-WAIT, between clock edges.
        stall    = 1'b0;
        flush    = 1'b0;
        bus_rdy  = 1'b0;
        bus_grnt = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (bus_as) found = 1'b1;
        end
        chk("reach_access", 32'(found), 32'd1);
        bus_grnt = 1'b0;
        cyc();
        chk("in_wait_req", 32'(bus_req), 32'd1);
        model_on = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req",  32'(bus_req),  32'd0);
        chk("arst_as",   32'(bus_as),   32'd0);
        chk("arst_err",  32'(err),      32'd0);
        chk("arst_insn", insn,          NOP);
        chk("arst_addr", 32'(bus_addr), 32'd0);
        chk("arst_busy", 32'(busy),     32'd1);
        stall = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        cyc();
        cyc();
        chk("idle_stall_req", 32'(bus_req), 32'd0);
        stall = 1'b0;
        cyc();
        chk("post_rst_req", 32'(bus_req), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
